// File: rtl/scarf_gpio_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : scarf_gpio_sampler
//  Desc     : SCARF slave capturing the GPIO bus into a buffer after a trigger.
//             Optional trigger timestamp enabled by SAMPLER_TIMESTAMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module scarf_gpio_sampler #(
   parameter logic [6:0] SLAVE_ID = 7'h05,
   parameter int         DEPTH    = 64,
   parameter int         AW       = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   input  logic       data_in_finished,
   input  logic [6:0] slave_id,
   input  logic       rnw,
   output logic [7:0] read_data_out,
   input  logic       trigger_in,
   input  logic [7:0] gpio_in,
   output logic       capture_done
);

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_armed   = 2'd1;
   localparam logic [1:0] c_st_capture = 2'd2;
   localparam logic [1:0] c_st_done    = 2'd3;

   localparam logic [2:0] c_reg_ctrl   = 3'd0;
   localparam logic [2:0] c_reg_status = 3'd1;
   localparam logic [2:0] c_reg_div    = 3'd2;
   localparam logic [2:0] c_reg_count  = 3'd3;
   localparam logic [2:0] c_reg_rd_ptr = 3'd4;
   localparam logic [2:0] c_reg_data   = 3'd5;
   localparam logic [2:0] c_reg_ts_lo  = 3'd6;
   localparam logic [2:0] c_reg_ts_hi  = 3'd7;

   localparam logic [AW:0] c_last_wr = (AW+1)'(DEPTH - 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;

   logic [7:0]    r_gpio_meta;
   logic [7:0]    r_gpio_sync;
   logic          r_trig_meta;
   logic          r_trig_sync;
   logic          r_trig_dly;
   logic          w_trig_edge;

   logic          r_byte_seen;
   logic [2:0]    r_addr;
   logic [7:0]    r_div;
   logic [7:0]    r_div_cnt;
   logic [AW:0]   r_wr_cnt;
   logic [AW-1:0] r_rd_ptr;
   logic          r_ovf;
   logic [7:0]    r_buf [DEPTH];

   logic          w_sel;
   logic          w_byte;
   logic          w_wr_en;
   logic          w_ctrl_wr;
   logic          w_arm;
   logic          w_clr;
   logic          w_rearm;
   logic          w_capture_start;
   logic          w_sample_tick;
   logic          w_last_sample;
   logic          w_rdptr_wr;
   logic          w_data_adv;
   logic          w_buf_we;
   logic [AW-1:0] w_buf_idx;
   logic [7:0]    w_count;
   logic [15:0]   w_ts;

   logic          w_armed;
   logic          w_capturing;
   logic          w_done;

   // Both pin groups share the same two-stage delay so buf[0] lines up with
   // the GPIO value present when the trigger pin was first seen high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gpio_meta <= 8'h00;
         r_gpio_sync <= 8'h00;
         r_trig_meta <= 1'b0;
         r_trig_sync <= 1'b0;
         r_trig_dly  <= 1'b0;
      end else begin
         r_gpio_meta <= gpio_in;
         r_gpio_sync <= r_gpio_meta;
         r_trig_meta <= trigger_in;
         r_trig_sync <= r_trig_meta;
         r_trig_dly  <= r_trig_sync;
      end
   end

   assign w_trig_edge = r_trig_sync & ~r_trig_dly;

   assign w_sel      = (slave_id == SLAVE_ID);
   assign w_byte     = data_in_valid & w_sel;
   assign w_wr_en    = w_byte & r_byte_seen & ~rnw;
   assign w_ctrl_wr  = w_wr_en & (r_addr == c_reg_ctrl);
   assign w_arm      = w_ctrl_wr & data_in[0];
   assign w_clr      = w_ctrl_wr & data_in[1];
   assign w_rearm    = w_arm & (r_state != c_st_capture);
   assign w_rdptr_wr = w_wr_en & (r_addr == c_reg_rd_ptr);
   assign w_data_adv = w_byte & r_byte_seen & rnw & (r_addr == c_reg_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte_seen <= 1'b0;
         r_addr      <= 3'd0;
      end else if (data_in_finished) begin
         r_byte_seen <= 1'b0;
      end else if (w_byte) begin
         if (!r_byte_seen) begin
            r_addr      <= data_in[2:0];
            r_byte_seen <= 1'b1;
         end else if (!(rnw && (r_addr == c_reg_data))) begin
            r_addr <= r_addr + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= 8'h00;
      end else if (w_wr_en && (r_addr == c_reg_div)) begin
         r_div <= data_in;
      end
   end

   // A re-arm while already armed restarts cleanly rather than racing a trigger.
   assign w_capture_start = (r_state == c_st_armed) & w_trig_edge & ~w_arm & ~w_clr;
   assign w_sample_tick   = (r_state == c_st_capture) & (r_div_cnt == 8'h00) & ~w_clr;
   assign w_last_sample   = w_sample_tick & (r_wr_cnt == c_last_wr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:    if (w_arm)           w_state_nxt = c_st_armed;
         c_st_armed:   if (w_capture_start) w_state_nxt = c_st_capture;
         c_st_capture: if (w_last_sample)   w_state_nxt = c_st_done;
         c_st_done:    if (w_arm)           w_state_nxt = c_st_armed;
         default:                           w_state_nxt = c_st_idle;
      endcase
      if (w_clr) begin
         w_state_nxt = c_st_idle;
      end
   end

   always_comb begin
      w_armed      = 1'b0;
      w_capturing  = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         c_st_armed:   w_armed     = 1'b1;
         c_st_capture: w_capturing = 1'b1;
         c_st_done:    w_done      = 1'b1;
         default:      ;
      endcase
   end

   assign capture_done = w_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_cnt  <= '0;
         r_rd_ptr  <= '0;
         r_ovf     <= 1'b0;
         r_div_cnt <= 8'h00;
      end else if (w_clr) begin
         r_wr_cnt  <= '0;
         r_rd_ptr  <= '0;
         r_ovf     <= 1'b0;
         r_div_cnt <= 8'h00;
      end else if (w_rearm) begin
         r_wr_cnt  <= '0;
         r_rd_ptr  <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_capture_start) begin
            r_wr_cnt  <= (AW+1)'(1);
            r_div_cnt <= r_div;
         end else if (w_sample_tick) begin
            r_wr_cnt  <= r_wr_cnt + (AW+1)'(1);
            r_div_cnt <= r_div;
         end else if (r_state == c_st_capture) begin
            r_div_cnt <= r_div_cnt - 8'd1;
         end
         if ((r_state == c_st_capture) && w_trig_edge) begin
            r_ovf <= 1'b1;
         end
         if (w_rdptr_wr) begin
            r_rd_ptr <= data_in[AW-1:0];
         end else if (w_data_adv) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   assign w_buf_we  = w_capture_start | w_sample_tick;
   assign w_buf_idx = w_capture_start ? '0 : r_wr_cnt[AW-1:0];

   always_ff @(posedge clk) begin
      if (w_buf_we) begin
         r_buf[w_buf_idx] <= r_gpio_sync;
      end
   end

`ifdef SAMPLER_TIMESTAMP_EN
   logic [15:0] r_ts_cnt;
   logic [15:0] r_ts_latch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ts_cnt   <= 16'h0000;
         r_ts_latch <= 16'h0000;
      end else begin
         r_ts_cnt <= r_ts_cnt + 16'd1;
         if (w_arm) begin
            r_ts_latch <= 16'h0000;
         end else if (w_capture_start) begin
            r_ts_latch <= r_ts_cnt;
         end
      end
   end

   assign w_ts = r_ts_latch;
`else
   assign w_ts = 16'h0000;
`endif

   // Full flag sits just above the pointer so COUNT reads DEPTH when complete.
   assign w_count = 8'(r_wr_cnt);

   always_comb begin
      read_data_out = 8'h00;
      if (w_sel && rnw && r_byte_seen) begin
         case (r_addr)
            c_reg_status: read_data_out = {4'b0000, r_ovf, w_done, w_capturing, w_armed};
            c_reg_div:    read_data_out = r_div;
            c_reg_count:  read_data_out = w_count;
            c_reg_rd_ptr: read_data_out = 8'(r_rd_ptr);
            c_reg_data:   read_data_out = r_buf[r_rd_ptr];
            c_reg_ts_lo:  read_data_out = w_ts[7:0];
            c_reg_ts_hi:  read_data_out = w_ts[15:8];
            default:      read_data_out = 8'h00;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scarf_gpio_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scarf_gpio_sampler
//  Desc     : Randomised GPIO capture against a pin-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scarf_gpio_sampler;

   localparam logic [6:0] SID   = 7'h05;
   localparam int         DEPTH = 64;
   localparam int         HMASK = 16383;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_finished = 1'b0;
   logic [6:0] slave_id = 7'h00;
   logic       rnw = 1'b0;
   logic [7:0] read_data_out;
   logic       trigger_in = 1'b0;
   logic [7:0] gpio_in = 8'h00;
   logic       capture_done;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] hist [0:HMASK];

   scarf_gpio_sampler #(.SLAVE_ID(SID), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .data_in          (data_in),
      .data_in_valid    (data_in_valid),
      .data_in_finished (data_in_finished),
      .slave_id         (slave_id),
      .rnw              (rnw),
      .read_data_out    (read_data_out),
      .trigger_in       (trigger_in),
      .gpio_in          (gpio_in),
      .capture_done     (capture_done)
   );

   always #5 clk = ~clk;

   // hist[n] holds the pin value sampled by clock edge n.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      gpio_in = 8'($urandom);
      hist[(cyc + 1) & HMASK] = gpio_in;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_in       = b;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
   endtask

   task automatic end_txn();
      data_in_finished = 1'b1;
      tick();
      data_in_finished = 1'b0;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      slave_id = SID;
      rnw      = 1'b0;
      send_byte(a);
      send_byte(d);
      end_txn();
   endtask

   task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
      slave_id = SID;
      rnw      = 1'b1;
      send_byte(a);
      v = read_data_out;
      end_txn();
   endtask

   task automatic fire_trigger(output int t1);
      trigger_in = 1'b1;
      t1 = cyc + 1;
      tick();
      tick();
      trigger_in = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (capture_done) break;
         tick();
      end
      check_eq("capture_done", 32'(capture_done), 32'd1);
   endtask

   // Sample k is the pin value at the trigger's first sampling edge plus k periods.
   task automatic check_capture(input string tag, input int t1, input int div);
      wr_reg(8'h04, 8'h00);
      slave_id = SID;
      rnw      = 1'b1;
      send_byte(8'h05);
      for (int k = 0; k < DEPTH; k++) begin
         check_eq(tag, 32'(read_data_out), 32'(hist[(t1 + k * (div + 1)) & HMASK]));
         send_byte(8'h00);
      end
      end_txn();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      logic [15:0] exp_ts;
      int t1;
      int rel;

      repeat (3) tick();
      reset = 1'b0;
      tick();

      check_eq("rst_done", 32'(capture_done), 32'd0);
      check_eq("rst_rdo", 32'(read_data_out), 32'd0);
      rd_reg(8'h01, v); check_eq("rst_status", 32'(v), 32'h00);
      rd_reg(8'h02, v); check_eq("rst_div", 32'(v), 32'h00);
      wr_reg(8'h02, 8'h5A);
      rd_reg(8'h02, v); check_eq("div_rw", 32'(v), 32'h5A);
      slave_id = 7'h03;
      rnw      = 1'b1;
      send_byte(8'h02);
      check_eq("other_slave_rdo", 32'(read_data_out), 32'd0);
      end_txn();

      // Back-to-back capture, DIV=0
      wr_reg(8'h02, 8'h00);
      wr_reg(8'h00, 8'h01);
      rd_reg(8'h01, v); check_eq("armed_status", 32'(v), 32'h01);
      repeat ($urandom_range(0, 7)) tick();
      fire_trigger(t1);
      wait_done(DEPTH + 20);
      rd_reg(8'h03, v); check_eq("count_full", 32'(v), 32'h40);
      rd_reg(8'h01, v); check_eq("done_status", 32'(v), 32'h04);
      check_capture("data_div0", t1, 0);

      // Spaced capture with a second trigger mid-way
      wr_reg(8'h02, 8'h03);
      wr_reg(8'h00, 8'h01);
      repeat ($urandom_range(0, 7)) tick();
      fire_trigger(t1);
      repeat (20) tick();
      rd_reg(8'h01, v); check_eq("capturing_status", 32'(v), 32'h02);
      trigger_in = 1'b1;
      tick();
      tick();
      trigger_in = 1'b0;
      wait_done(DEPTH * 4 + 20);
      rd_reg(8'h01, v); check_eq("ovf_status", 32'(v), 32'h0C);
      check_capture("data_div3", t1, 3);

      // CLR wins over ARM in the same byte
      wr_reg(8'h00, 8'h01);
      wr_reg(8'h00, 8'h03);
      rd_reg(8'h01, v); check_eq("clr_status", 32'(v), 32'h00);
      rd_reg(8'h03, v); check_eq("clr_count", 32'(v), 32'h00);
      fire_trigger(t1);
      repeat (10) tick();
      check_eq("clr_no_done", 32'(capture_done), 32'd0);
      rd_reg(8'h01, v); check_eq("clr_idle", 32'(v), 32'h00);

      // Reset at sample 20 of a capture
      wr_reg(8'h02, 8'h00);
      wr_reg(8'h00, 8'h01);
      fire_trigger(t1);
      repeat (21) tick();
      slave_id = SID;
      rnw      = 1'b1;
      reset    = 1'b1;
      #2;
      check_eq("midrst_done", 32'(capture_done), 32'd0);
      check_eq("midrst_rdo", 32'(read_data_out), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      rel   = cyc;
      tick();
      rd_reg(8'h01, v); check_eq("midrst_status", 32'(v), 32'h00);
      rd_reg(8'h03, v); check_eq("midrst_count", 32'(v), 32'h00);
      rd_reg(8'h04, v); check_eq("midrst_rdptr", 32'(v), 32'h00);
      wr_reg(8'h00, 8'h01);
      repeat ($urandom_range(0, 7)) tick();
      fire_trigger(t1);
      wait_done(DEPTH + 20);
      rd_reg(8'h03, v); check_eq("recap_count", 32'(v), 32'h40);
      check_capture("data_recap", t1, 0);

`ifdef SAMPLER_TIMESTAMP_EN
      exp_ts = 16'(t1 + 1 - rel);
`else
      exp_ts = 16'h0000;
`endif
      rd_reg(8'h06, v); check_eq("ts_lo", 32'(v), 32'(exp_ts[7:0]));
      rd_reg(8'h07, v); check_eq("ts_hi", 32'(v), 32'(exp_ts[15:8]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scarf_gpio_sampler.md
Name: scarf_gpio_sampler

Overview:
- SCARF slave that records the 8-bit GPIO bus into an internal buffer, starting when the trigger output from scarf_trigger fires.
- Sits directly downstream of scarf_trigger in the top level: its trigger_in is driven by trigger_out.
- Shares the SCARF byte stream with the other slaves. Its read_data_out is ORed into the read_data_in bus.
- Host arms it over SPI, waits for capture_done, then reads the samples back through a data window register.

Parameters:
- SLAVE_ID, 7'h05, SCARF slave address.
- DEPTH, 64, samples per capture (power of 2).
- AW, $clog2(DEPTH), buffer pointer width.

Ports:
- clk  input  1  FPGA board clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  SCARF byte.
- data_in_valid  input  1  one-cycle strobe, data_in valid.
- data_in_finished  input  1  one-cycle strobe, SPI transaction ended.
- slave_id  input  7  addressed slave for the current transaction.
- rnw  input  1  1 = read transaction.
- read_data_out  output  8  read byte; 0 when not selected.
- trigger_in  input  1  from scarf_trigger trigger_out (async).
- gpio_in  input  8  sampled pins (async).
- capture_done  output  1  high in DONE state.

Behaviour:
- Clock and reset: all flops are on clk, asynchronously cleared by reset. Buffer RAM contents are not reset.
- Input sync: gpio_in and trigger_in each pass through a 2-flop synchronizer. The trigger edge is the registered rising edge of the synced trigger.

SCARF access:
- sel = (slave_id == SLAVE_ID).
- The first data_in_valid byte of a selected transaction is the register address. It is loaded into addr[2:0]; upper bits are ignored.
- Each later data_in_valid byte:
  - Write (rnw=0): writes addr, then addr increments.
  - Read (rnw=1): addr increments, except at DATA, where addr holds.
- data_in_finished clears the byte counter.
- read_data_out = reg[addr] when sel && rnw && byte counter ≥ 1; otherwise 8'h00.

Register map:
- 0x00 CTRL (W)
  - bit0 ARM: starts a capture.
  - bit1 CLR: forces IDLE and zeroes both pointers.
  - Reads 0.
- 0x01 STATUS (R): {4'b0, overflow_trig, done, capturing, armed}.
- 0x02 DIV (RW), reset 0: one sample every DIV+1 clocks.
- 0x03 COUNT (R): {(8-AW-1)'b0, wr_ptr_full_flag, wr_ptr}. Equals DEPTH once full.
- 0x04 RD_PTR (RW): read pointer. A write sets it.
- 0x05 DATA (R):
  - Returns buf[rd_ptr].
  - rd_ptr increments (wraps mod DEPTH) on each data_in_valid while addr==5 && rnw.
- 0x06/0x07: see Optional Feature.

State machine:
- IDLE: ARM write → ARMED. On entry, wr_ptr=0, rd_ptr=0, overflow_trig=0.
- ARMED: trigger edge → CAPTURE.
  - gpio_sync is written to buf[0] in that same cycle.
  - wr_ptr=1 and the divider counter loads DIV.
- CAPTURE:
  - Divider counts down; at 0 it writes buf[wr_ptr], increments wr_ptr, and reloads DIV.
  - After the DEPTH-th write → DONE.
  - A trigger edge during CAPTURE sets overflow_trig and is otherwise ignored.
- DONE:
  - capture_done=1.
  - ARM → ARMED (pointers cleared).
  - Trigger edges are ignored.
- CLR (any state) → IDLE. CLR has priority over ARM when both are set in the same byte.
- DIV written mid-capture takes effect at the next reload.

Timing:
- Sample spacing is exactly DIV+1 clocks.
- Latency from trigger_in pin to the first sample is 3 clocks (2 sync + edge register).

Reset values:
- read_data_out=0, capture_done=0, state=IDLE, DIV=0, pointers=0, flags=0.
- Reset mid-capture aborts the capture to IDLE.

Optional Feature:
- Macro: SAMPLER_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running counter (wraps at 16'hFFFF) runs from reset.
  - Its value is latched on the trigger edge that enters CAPTURE.
  - Registers 0x06/0x07 return the latched timestamp low/high bytes.
  - The latch is cleared by ARM and by reset.
- Undefined: no counter is built; 0x06/0x07 read 8'h00.

Test Plan:
- Reset then read 0x01 and 0x02 → 8'h00, 8'h00; capture_done=0; read_data_out=0 while another slave_id is addressed.
- DIV=0, ARM, gpio_in counting 0,1,2… per clock, pulse trigger_in → capture_done after 64 samples; COUNT=8'h40. Write RD_PTR=0, read DATA ×64 → consecutive values, no gaps.
- DIV=3, ARM, trigger → 64 samples spaced 4 clocks apart. Second trigger pulse mid-capture → STATUS bit3=1, data unaffected.
- ARM then write CTRL=8'h03 (CLR+ARM) → STATUS=8'h00, state IDLE. Trigger ignored; capture_done stays 0.
- Assert reset during CAPTURE at sample 20 → all outputs 0. A new ARM+trigger captures a full 64 samples from buf[0].
- With SAMPLER_TIMESTAMP_EN: trigger at counter 16'h1234 (synced edge) → 0x06/0x07 read 8'h34/8'h12. Without the macro → 8'h00/8'h00.
